reg_file_mp: RTL and testbench

Parametrised multi-port register file for the CPU datapath: two read ports with registered and combinational outputs, two write ports with fixed priority, optional write-to-read bypass, optional hardwired-zero entry 0, and a debug read port. It adds a sequenced bulk-clear engine that zeroes the array one entry per cycle without asserting reset. It sits between decode (read addresses) and writeback (write ports).

---
 rtl/reg_file_mp_if.sv | 39 +++
 rtl/reg_file_mp.sv | 106 ++++++++++
 tb/tb_reg_file_mp.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_file_mp_if : read/write/clear/debug bundle for reg_file_mp      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] rd_comb_a;
  logic [DATA_W-1:0] rd_comb_b;
  logic              wr_en_0;
  logic              wr_en_1;
  logic [ADDR_W-1:0] wr_addr_0;
  logic [ADDR_W-1:0] wr_addr_1;
  logic [DATA_W-1:0] wr_data_0;
  logic [DATA_W-1:0] wr_data_1;
  logic              clr_req;
  logic              clr_busy;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en_0, wr_en_1, wr_addr_0, wr_addr_1,
           wr_data_0, wr_data_1, clr_req, dbg_addr,
    input  rd_data_a, rd_data_b, rd_comb_a, rd_comb_b, clr_busy, dbg_data
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en_0, wr_en_1, wr_addr_0, wr_addr_1,
           wr_data_0, wr_data_1, clr_req, dbg_addr,
    output rd_data_a, rd_data_b, rd_comb_a, rd_comb_b, clr_busy, dbg_data
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_file_mp : 2R/2W register file with bypass, zero reg, bulk clear |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  reg_file_mp_if.slave  bus
);
  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_a_q, rd_a_d;
  logic [DATA_W-1:0] rd_b_q, rd_b_d;

  logic w_zero_wr0, w_zero_wr1, w_zero_rda, w_zero_rdb, w_zero_dbg;

  assign w_zero_wr0 = (ZERO_REG != 0) && (bus.wr_addr_0 == '0);
  assign w_zero_wr1 = (ZERO_REG != 0) && (bus.wr_addr_1 == '0);
  assign w_zero_rda = (ZERO_REG != 0) && (bus.rd_addr_a == '0);
  assign w_zero_rdb = (ZERO_REG != 0) && (bus.rd_addr_b == '0);
  assign w_zero_dbg = (ZERO_REG != 0) && (bus.dbg_addr  == '0);

  // mem_d is the post-edge array, so it doubles as the bypass source.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    mem_d   = mem_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.wr_en_0 && !w_zero_wr0) mem_d[bus.wr_addr_0] = bus.wr_data_0;
        if (bus.wr_en_1 && !w_zero_wr1) mem_d[bus.wr_addr_1] = bus.wr_data_1;
        if (bus.clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_CLEAR: begin
        mem_d[cnt_q] = '0;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    rd_a_d = '0;
    rd_b_d = '0;
    if (!w_zero_rda) rd_a_d = (BYPASS != 0) ? mem_d[bus.rd_addr_a] : mem_q[bus.rd_addr_a];
    if (!w_zero_rdb) rd_b_d = (BYPASS != 0) ? mem_d[bus.rd_addr_b] : mem_q[bus.rd_addr_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.rd_data_a = rd_a_q;
  assign bus.rd_data_b = rd_b_q;
  assign bus.clr_busy  = busy_q;
  assign bus.rd_comb_a = w_zero_rda ? '0 : mem_q[bus.rd_addr_a];
  assign bus.rd_comb_b = w_zero_rdb ? '0 : mem_q[bus.rd_addr_b];
  assign bus.dbg_data  = w_zero_dbg ? '0 : mem_q[bus.dbg_addr];
endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_reg_file_mp : randomized bench for reg_file_mp vs array model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_reg_file_mp;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 32;
  localparam int ZERO_REG = 1;
  localparam int BYPASS   = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model [DEPTH];
  int          clr_left = 0;
  int          clr_idx  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] peek(input int a);
    return (ZERO_REG != 0 && a == 0) ? 32'd0 : model[a];
  endfunction

  task automatic idle_inputs();
    bus.wr_en_0 = 1'b0; bus.wr_en_1 = 1'b0; bus.clr_req = 1'b0;
    bus.wr_addr_0 = '0; bus.wr_addr_1 = '0;
    bus.wr_data_0 = '0; bus.wr_data_1 = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.dbg_addr = '0;
  endtask

  // One clock: check combinational view, then registered reads after the edge.
  task automatic step();
    logic [31:0] nxt [DEPTH];
    logic [31:0] ea, eb;
    int a, b;
    @(negedge clk);
    check("rd_comb_a", bus.rd_comb_a, peek(int'(bus.rd_addr_a)));
    check("rd_comb_b", bus.rd_comb_b, peek(int'(bus.rd_addr_b)));
    check("dbg_data",  bus.dbg_data,  peek(int'(bus.dbg_addr)));
    check("clr_busy",  32'(bus.clr_busy), (clr_left > 0) ? 32'd1 : 32'd0);
    nxt = model;
    if (clr_left > 0) begin
      nxt[clr_idx] = 32'd0;
      clr_idx++;
      clr_left--;
    end else begin
      if (bus.wr_en_0 && !(ZERO_REG != 0 && bus.wr_addr_0 == 0)) nxt[bus.wr_addr_0] = bus.wr_data_0;
      if (bus.wr_en_1 && !(ZERO_REG != 0 && bus.wr_addr_1 == 0)) nxt[bus.wr_addr_1] = bus.wr_data_1;
      if (bus.clr_req) begin
        clr_left = DEPTH;
        clr_idx  = 0;
      end
    end
    a  = int'(bus.rd_addr_a);
    b  = int'(bus.rd_addr_b);
    ea = (ZERO_REG != 0 && a == 0) ? 32'd0 : ((BYPASS != 0) ? nxt[a] : model[a]);
    eb = (ZERO_REG != 0 && b == 0) ? 32'd0 : ((BYPASS != 0) ? nxt[b] : model[b]);
    model = nxt;
    @(posedge clk);
    #1;
    check("rd_data_a", bus.rd_data_a, ea);
    check("rd_data_b", bus.rd_data_b, eb);
  endtask

  task automatic rand_inputs(input bit allow_clr);
    bit narrow;
    narrow = ($urandom_range(0, 3) == 0);
    bus.wr_en_0   = $urandom_range(0, 1) == 1;
    bus.wr_en_1   = $urandom_range(0, 1) == 1;
    bus.wr_addr_0 = narrow ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
    bus.wr_addr_1 = narrow ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
    bus.wr_data_0 = $urandom;
    bus.wr_data_1 = $urandom;
    bus.rd_addr_a = narrow ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
    bus.rd_addr_b = ADDR_W'($urandom);
    bus.dbg_addr  = ADDR_W'($urandom);
    bus.clr_req   = allow_clr && ($urandom_range(0, 63) == 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    clr_left = 0;
    clr_idx  = 0;
  endtask

  task automatic sweep_all();
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_addr_a = ADDR_W'(i);
      bus.rd_addr_b = ADDR_W'(DEPTH - 1 - i);
      bus.dbg_addr  = ADDR_W'(i);
      step();
    end
  endtask

  task automatic fill_plus_one();
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en_0   = 1'b1;
      bus.wr_addr_0 = ADDR_W'(i);
      bus.wr_data_0 = 32'(i + 1);
      bus.rd_addr_a = ADDR_W'(i);
      bus.dbg_addr  = ADDR_W'(i);
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #12;
    check("rst_rd_data_a", bus.rd_data_a, 32'd0);
    check("rst_rd_data_b", bus.rd_data_b, 32'd0);
    check("rst_clr_busy",  32'(bus.clr_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sweep_all();

    // Same-edge bypass of a port-0 write.
    bus.wr_en_0 = 1'b1; bus.wr_addr_0 = 5'd5; bus.wr_data_0 = 32'hDEADBEEF;
    bus.rd_addr_a = 5'd5; bus.dbg_addr = 5'd5;
    step();
    check("bypass_addr5", bus.rd_data_a, 32'hDEADBEEF);
    bus.wr_en_0 = 1'b0;
    step();

    // Port 1 wins on an address collision.
    bus.wr_en_0 = 1'b1; bus.wr_addr_0 = 5'd7; bus.wr_data_0 = 32'h1111_1111;
    bus.wr_en_1 = 1'b1; bus.wr_addr_1 = 5'd7; bus.wr_data_1 = 32'h2222_2222;
    bus.rd_addr_a = 5'd7; bus.rd_addr_b = 5'd7; bus.dbg_addr = 5'd7;
    step();
    check("collide_addr7", bus.rd_data_b, 32'h2222_2222);
    idle_inputs();
    bus.rd_addr_a = 5'd7; bus.dbg_addr = 5'd7;
    step();

    // Writes to entry 0 are dropped.
    bus.wr_en_0 = 1'b1; bus.wr_addr_0 = 5'd0; bus.wr_data_0 = 32'hFFFF_FFFF;
    bus.wr_en_1 = 1'b1; bus.wr_addr_1 = 5'd0; bus.wr_data_1 = 32'hFFFF_FFFF;
    bus.rd_addr_a = 5'd0; bus.rd_addr_b = 5'd0; bus.dbg_addr = 5'd0;
    step();
    check("zero_reg_rd", bus.rd_data_a, 32'd0);
    idle_inputs();
    step();

    // Full clear with random writes attempted throughout the busy window.
    fill_plus_one();
    bus.clr_req = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) begin
      rand_inputs(1'b1);
      step();
    end
    check("clr_done_busy", 32'(bus.clr_busy), 32'd0);
    sweep_all();

    // Reset asserted partway through a clear.
    fill_plus_one();
    bus.clr_req = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midclr_rst_busy", 32'(bus.clr_busy), 32'd0);
    check("midclr_rst_rd_a", bus.rd_data_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sweep_all();
    fill_plus_one();
    bus.clr_req = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < DEPTH + 2; i++) begin
      bus.dbg_addr  = ADDR_W'(i % DEPTH);
      bus.rd_addr_a = ADDR_W'(i % DEPTH);
      step();
    end

    for (int n = 0; n < 800; n++) begin
      rand_inputs(1'b1);
      step();
    end
    idle_inputs();
    for (int i = 0; i < DEPTH + 1; i++) step();
    sweep_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
